// File: rtl/vga_pkg.sv
// Shared constants and helpers for the VGA text renderer: default 640x480
// timing, special glyph codes, RGB332 colours and the glyph bit picker.
package vga_pkg;

  // Default 640x480@60 timing, in pixels and lines
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int DEF_H_TOTAL      = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL      = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
  localparam int DEF_H_SYNC_START = DEF_H_ACTIVE + DEF_H_FP;
  localparam int DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC;
  localparam int DEF_V_SYNC_START = DEF_V_ACTIVE + DEF_V_FP;
  localparam int DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC;

  // Glyph ROM codes with fixed meaning
  localparam logic [5:0] SPACE_CODE = 6'b111110;
  localparam logic [5:0] COLON_CODE = 6'b111111;

  // RGB332 colours
  localparam logic [7:0] DEF_FG_COLOR = 8'hFF;
  localparam logic [7:0] DEF_BG_COLOR = 8'h00;
  localparam logic [7:0] BLANK_COLOR  = 8'h00;

  // Seven glyph columns, index n = column n; bit r of a column = glyph row r
  typedef logic [6:0][7:0] glyph_cols_t;

  // Pixel bit at (sel,row) of a cell; column 7 is the blank inter-character gap
  function automatic logic glyph_bit(input glyph_cols_t cols,
                                     input logic [2:0] sel,
                                     input logic [2:0] row);
    logic b;
    b = 1'b0;
    if (sel != 3'd7) b = cols[sel][row];
    return b;
  endfunction

endpackage

// File: rtl/vga_text_render_if.sv
// Bundle of the renderer's text-buffer, glyph-ROM and video-output signals.
// master = renderer side, slave = buffer/ROM/display side.
interface vga_text_render_if;
  logic [12:0] text_addr;
  logic [5:0]  char_code;
  logic [5:0]  font_code;
  logic [7:0]  col0;
  logic [7:0]  col1;
  logic [7:0]  col2;
  logic [7:0]  col3;
  logic [7:0]  col4;
  logic [7:0]  col5;
  logic [7:0]  col6;
  logic        hsync;
  logic        vsync;
  logic        de;
  logic [7:0]  rgb;

  modport master (
    output text_addr, font_code, hsync, vsync, de, rgb,
    input  char_code, col0, col1, col2, col3, col4, col5, col6
  );

  modport slave (
    input  text_addr, font_code, hsync, vsync, de, rgb,
    output char_code, col0, col1, col2, col3, col4, col5, col6
  );
endinterface

// File: rtl/vga_timing.sv
// Horizontal/vertical raster counters with stage-0 active and sync flags.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] h_cnt,
  output logic [2:0] cell_y,
  output logic       active,
  output logic       hsync,
  output logic       vsync,
  output logic       line_end,
  output logic       frame_end
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  logic [9:0] h_reg;
  logic [9:0] v_reg;

  assign line_end  = (h_reg == 10'(H_TOTAL - 1));
  assign frame_end = line_end && (v_reg == 10'(V_TOTAL - 1));

  // Pixel counter wraps every line; line counter steps on each wrap and wraps per frame
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_reg <= '0;
      v_reg <= '0;
    end else if (line_end) begin
      h_reg <= '0;
      v_reg <= frame_end ? 10'd0 : v_reg + 10'd1;
    end else begin
      h_reg <= h_reg + 10'd1;
    end
  end

  assign h_cnt  = h_reg;
  assign cell_y = v_reg[2:0];
  assign active = (h_reg < 10'(H_ACTIVE)) && (v_reg < 10'(V_ACTIVE));
  assign hsync  = !((h_reg >= 10'(H_ACTIVE + H_FP)) &&
                    (h_reg <  10'(H_ACTIVE + H_FP + H_SYNC)));
  assign vsync  = !((v_reg >= 10'(V_ACTIVE + V_FP)) &&
                    (v_reg <  10'(V_ACTIVE + V_FP + V_SYNC)));

endmodule

// File: rtl/vga_text_render.sv
// 80x60 text-mode renderer: walks the raster, fetches char codes from the
// text buffer, drives the glyph ROM and outputs pixels 3 clk after the
// counter position, with sync/de/rgb kept mutually aligned.
module vga_text_render
  import vga_pkg::*;
#(
  parameter int         H_ACTIVE = DEF_H_ACTIVE,
  parameter int         H_FP     = DEF_H_FP,
  parameter int         H_SYNC   = DEF_H_SYNC,
  parameter int         H_BP     = DEF_H_BP,
  parameter int         V_ACTIVE = DEF_V_ACTIVE,
  parameter int         V_FP     = DEF_V_FP,
  parameter int         V_SYNC   = DEF_V_SYNC,
  parameter int         V_BP     = DEF_V_BP,
  parameter logic [7:0] FG_COLOR = DEF_FG_COLOR,
  parameter logic [7:0] BG_COLOR = DEF_BG_COLOR
) (
  input  logic                clk,
  input  logic                rst,
  vga_text_render_if.master   bus
);

  localparam int TEXT_COLS = H_ACTIVE / 8;

  logic [9:0]  h_cnt;
  logic [2:0]  cell_y;
  logic        active_0;
  logic        hsync_0;
  logic        vsync_0;
  logic        line_end;
  logic        frame_end;

  logic [12:0] row_base;

  logic        active_1, active_2;
  logic [2:0]  x_1, x_2;
  logic [2:0]  y_1, y_2;
  logic        hsync_1, hsync_2;
  logic        vsync_1, vsync_2;

  logic        hsync_reg;
  logic        vsync_reg;
  logic        de_reg;
  logic [7:0]  rgb_reg;

  glyph_cols_t glyph;
  logic        pix_bit;

  vga_timing #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk       (clk),
    .rst       (rst),
    .h_cnt     (h_cnt),
    .cell_y    (cell_y),
    .active    (active_0),
    .hsync     (hsync_0),
    .vsync     (vsync_0),
    .line_end  (line_end),
    .frame_end (frame_end)
  );

  // Start address of the current text row; frame wrap takes priority over the row step
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_base <= '0;
    end else if (line_end) begin
      if (frame_end)
        row_base <= '0;
      else if (cell_y == 3'd7)
        row_base <= row_base + 13'(TEXT_COLS);
    end
  end

  // Cell address is an add, not a multiply: row start plus pixel/8
  assign bus.text_addr = row_base + {6'd0, h_cnt[9:3]};

  // Stage 1: delay position and sync to match the text buffer read latency
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active_1 <= 1'b0;
      x_1      <= '0;
      y_1      <= '0;
      hsync_1  <= 1'b1;
      vsync_1  <= 1'b1;
    end else begin
      active_1 <= active_0;
      x_1      <= h_cnt[2:0];
      y_1      <= cell_y;
      hsync_1  <= hsync_0;
      vsync_1  <= vsync_0;
    end
  end

  // Blank cells outside the picture so the ROM never lights a pixel in blanking
  assign bus.font_code = active_1 ? bus.char_code : SPACE_CODE;

  // Stage 2: delay again to match the glyph ROM latency
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active_2 <= 1'b0;
      x_2      <= '0;
      y_2      <= '0;
      hsync_2  <= 1'b1;
      vsync_2  <= 1'b1;
    end else begin
      active_2 <= active_1;
      x_2      <= x_1;
      y_2      <= y_1;
      hsync_2  <= hsync_1;
      vsync_2  <= vsync_1;
    end
  end

  assign glyph   = {bus.col6, bus.col5, bus.col4, bus.col3, bus.col2, bus.col1, bus.col0};
  assign pix_bit = glyph_bit(glyph, x_2, y_2);

  // Stage 3: registered video outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hsync_reg <= 1'b1;
      vsync_reg <= 1'b1;
      de_reg    <= 1'b0;
      rgb_reg   <= BLANK_COLOR;
    end else begin
      hsync_reg <= hsync_2;
      vsync_reg <= vsync_2;
      de_reg    <= active_2;
      rgb_reg   <= active_2 ? (pix_bit ? FG_COLOR : BG_COLOR) : BLANK_COLOR;
    end
  end

  assign bus.hsync = hsync_reg;
  assign bus.vsync = vsync_reg;
  assign bus.de    = de_reg;
  assign bus.rgb   = rgb_reg;

endmodule

// File: doc/vga_text_render.md
Name: vga_text_render

Overview:
- Downstream consumer of the glyph ROM stage (`RAM_set`: 6-bit char code in, seven 8-bit column bytes out, one clk of latency).
- Generates 640x480 VGA timing and walks an 80x60 grid of 8x8 text cells.
- Fetches the char code for each cell from the text buffer and drives it to the glyph ROM.
- Selects the current pixel bit from the returned columns and outputs registered sync, data-enable and colour, all aligned to each other.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync pulse width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync pulse width
- V_BP, 33, vertical back porch
- TEXT_COLS, 80, cells per row (H_ACTIVE/8)
- FG_COLOR, 8'hFF, RGB332 colour for a lit glyph pixel
- BG_COLOR, 8'h00, RGB332 colour for an unlit active pixel

Ports:
- clk  in  1  pixel clock (25 MHz nominal)
- rst  in  1  asynchronous, active-low reset
- text_addr  out  13  text buffer address = cell_row*TEXT_COLS + cell_col
- char_code  in  6  text buffer read data; synchronous read, valid 1 clk after text_addr
- font_code  out  6  char code to the glyph ROM
- col0..col6  in  8 each  glyph column bytes from the ROM, valid 1 clk after font_code; bit n = glyph row n, bit 0 top
- hsync  out  1  horizontal sync, active low
- vsync  out  1  vertical sync, active low
- de  out  1  active-video flag, aligned with rgb
- rgb  out  8  RGB332 pixel

Behaviour:
- Counters:
  - h_cnt runs 0..H_total-1, where H_total = H_ACTIVE+H_FP+H_SYNC+H_BP = 800.
  - v_cnt runs 0..V_total-1, where V_total = 525.
  - v_cnt increments when h_cnt wraps; both wrap to 0 at the end of the frame.
- Active region: h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
- Sync windows (stage-0 values, low inside the window, high outside):
  - hsync_0 low for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
  - vsync_0 low for V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC.
- text_addr:
  - Equals row_base + h_cnt[9:3], combinational from registers; no multiplier.
  - row_base is a register: cleared at frame wrap, += TEXT_COLS when h_cnt wraps and v_cnt[2:0]==7.
  - Outside the active region, text_addr holds the don't-care computed value; no requirement on it.
- Pipeline, with stage 0 = counter values at cycle t:
  - t+1: char_code returns. font_code = char_code if active_1, else 6'b111110 (space). Combinational.
  - t+2: col0..col6 valid.
  - At t+2 the pixel bit is computed: sel = x_2 (h_cnt[2:0] delayed 2), r = y_2 (v_cnt[2:0] delayed 2); bit = (sel==7) ? 0 : col[sel][r]. Cell column 7 is the inter-character gap.
  - t+3 (registered outputs): rgb = active_2 ? (bit ? FG_COLOR : BG_COLOR) : 8'h00; de = active_2; hsync/vsync = stage-0 values delayed 3.
- Total latency from counter position to output pins: 3 clk. All outputs stay mutually aligned.
- Reset (asynchronous, rst=0):
  - h_cnt, v_cnt, row_base and all delay registers clear.
  - Outputs: hsync=1, vsync=1, de=0, rgb=0.
  - text_addr=0 and font_code=6'b111110 (active_1 clears).
  - Release mid-frame restarts at (0,0); the first active pixel appears at the outputs 3 clk after release.
- Boundaries:
  - h_cnt wrap together with a cell-row end: row_base updates in the same cycle v_cnt increments.
  - v_cnt wrap overrides the row_base increment: row_base becomes 0.
  - Codes not defined in the glyph ROM are passed through unchanged; the ROM maps them to '*'.

Decomposition:
- Shared package vga_pkg holds:
  - the timing constants (H_*/V_* totals and sync windows)
  - the space code 6'b111110 and the colon code 6'b111111
  - the RGB332 colour constants
- One sub-module: vga_timing (h/v counters, active/hsync/vsync generation).
- Address and pixel pipeline logic stays in vga_text_render.

Test Plan:
- Free-run two frames after reset -> hsync low for exactly 96 clk every 800 clk; vsync low for exactly 2 lines (1600 clk) every 525 lines; de high for 640 clk per line on 480 lines.
- Observe text_addr at h_cnt=8, v_cnt=8 -> 81; at h_cnt=639, v_cnt=479 -> 4799; at h_cnt=0, v_cnt=0 of the next frame -> 0.
- Buffer returns code 6'b000001 ('1') for cell (0,0); ROM model returns col3=8'h7F, other columns per glyph -> at outputs 3 clk after h_cnt=3 on lines 0..6, rgb=FG_COLOR; on line 7, rgb=BG_COLOR; at x=7 on any line, rgb=BG_COLOR.
- Buffer returns 6'b111110 everywhere -> rgb=BG_COLOR for every active pixel; rgb=8'h00 and de=0 in blanking; font_code=6'b111110 during blanking regardless of char_code.
- Assert rst low at h_cnt=300, v_cnt=200 -> outputs immediately hsync=1, vsync=1, de=0, rgb=0; after release, the first de=1 appears exactly 3 clk later and text_addr restarts at 0.
